// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order core: load-use stalls, branch flushes, operand forwarding.
// Latency: all outputs combinational from decode inputs plus registered state/scoreboard (0 cycles).
// Backpressure: stalls fetch->decode and decode->execute for one cycle on load-use; squashes execute during flush.
//
// Ports:
//   clk, rst                       core clock, synchronous active-high reset
//   dec_*                          decode-stage instruction fields (valid, sources, destination, load flag)
//   branch_taken                   decode resolved a taken branch/jump this cycle
//   f_to_d_enable, d_to_e_enable   pipeline flop enables
//   d_to_e_bubble                  load a NOP into execute
//   flush_fetch                    discard the instruction currently in fetch
//   fwd_sel_rs1, fwd_sel_rs2       operand source: 0=RF 1=MEM load data 2=EX ALU 3=MEM ALU
module pipeline_hazard_ctrl #(
  parameter int REGISTER_SIZE = 5,
  parameter int FLUSH_CYCLES  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_valid,
  input  logic [REGISTER_SIZE-1:0] dec_rs1_addr,
  input  logic [REGISTER_SIZE-1:0] dec_rs2_addr,
  input  logic                     dec_rs1_used,
  input  logic                     dec_rs2_used,
  input  logic [REGISTER_SIZE-1:0] dec_rd_addr,
  input  logic                     dec_rd_write,
  input  logic                     dec_is_load,
  input  logic                     branch_taken,
  output logic                     f_to_d_enable,
  output logic                     d_to_e_enable,
  output logic                     d_to_e_bubble,
  output logic                     flush_fetch,
  output logic [1:0]               fwd_sel_rs1,
  output logic [1:0]               fwd_sel_rs2
);

  localparam logic [1:0] ST_RUN        = 2'd0;
  localparam logic [1:0] ST_LOAD_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH      = 2'd2;

  localparam logic [1:0] FWD_RF     = 2'd0;
  localparam logic [1:0] FWD_MEM_DM = 2'd1;
  localparam logic [1:0] FWD_EX_ALU = 2'd2;
  localparam logic [1:0] FWD_MEM_AL = 2'd3;

  // Counter counts remaining flush cycles after the current one.
  localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

  logic [1:0]               state_q, state_d;
  logic [1:0]               cnt_q, cnt_d;

  // Shadow scoreboard: destination of the instructions now in execute (E) and memory (M).
  logic                     e_vld_q, e_vld_d;
  logic [REGISTER_SIZE-1:0] e_rd_q, e_rd_d;
  logic                     e_load_q, e_load_d;
  logic                     m_vld_q;
  logic [REGISTER_SIZE-1:0] m_rd_q;
  logic                     m_load_q;

  logic rs1_e_hit, rs2_e_hit, rs1_m_hit, rs2_m_hit;
  logic load_use;

  // x0 is hardwired zero, so it never matches; dec_valid gates all matching.
  always_comb begin
    rs1_e_hit = dec_valid && dec_rs1_used && (dec_rs1_addr != '0) && e_vld_q && (e_rd_q == dec_rs1_addr);
    rs2_e_hit = dec_valid && dec_rs2_used && (dec_rs2_addr != '0) && e_vld_q && (e_rd_q == dec_rs2_addr);
    rs1_m_hit = dec_valid && dec_rs1_used && (dec_rs1_addr != '0) && m_vld_q && (m_rd_q == dec_rs1_addr);
    rs2_m_hit = dec_valid && dec_rs2_used && (dec_rs2_addr != '0) && m_vld_q && (m_rd_q == dec_rs2_addr);
    load_use  = e_load_q && (rs1_e_hit || rs2_e_hit);
  end

  function automatic logic [1:0] fwd_pick(input logic e_hit, input logic m_hit,
                                          input logic e_ld, input logic m_ld);
    // A load in E has no data yet; that case is a stall, so it falls through to M/RF.
    if (e_hit && !e_ld)  return FWD_EX_ALU;
    else if (m_hit)      return m_ld ? FWD_MEM_DM : FWD_MEM_AL;
    else                 return FWD_RF;
  endfunction

  always_comb begin
    f_to_d_enable = 1'b1;
    d_to_e_enable = 1'b1;
    d_to_e_bubble = 1'b0;
    flush_fetch   = 1'b0;
    fwd_sel_rs1   = FWD_RF;
    fwd_sel_rs2   = FWD_RF;
    state_d       = state_q;
    cnt_d         = cnt_q;
    if (!rst) begin
      fwd_sel_rs1 = fwd_pick(rs1_e_hit, rs1_m_hit, e_load_q, m_load_q);
      fwd_sel_rs2 = fwd_pick(rs2_e_hit, rs2_m_hit, e_load_q, m_load_q);
      case (state_q)
        ST_FLUSH: begin
          // Decode holds a wrong-path instruction; squash it and ignore its hazards/branches.
          d_to_e_bubble = 1'b1;
          flush_fetch   = 1'b1;
          if (cnt_q == 2'd0) state_d = ST_RUN;
          else               cnt_d   = cnt_q - 2'd1;
        end
        default: begin
          // RUN and LOAD_STALL share rules; stall wins over a simultaneous branch so the
          // branch re-resolves next cycle with the forwarded load data.
          if (load_use) begin
            f_to_d_enable = 1'b0;
            d_to_e_enable = 1'b0;
            d_to_e_bubble = 1'b1;
            state_d       = ST_LOAD_STALL;
          end else if (branch_taken && dec_valid) begin
            flush_fetch = 1'b1;
            cnt_d       = FLUSH_INIT;
            state_d     = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    e_vld_d  = dec_valid && dec_rd_write && !d_to_e_bubble;
    e_rd_d   = dec_rd_addr;
    e_load_d = dec_is_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      cnt_q    <= 2'd0;
      e_vld_q  <= 1'b0;
      e_rd_q   <= '0;
      e_load_q <= 1'b0;
      m_vld_q  <= 1'b0;
      m_rd_q   <= '0;
      m_load_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      e_vld_q  <= e_vld_d;
      e_rd_q   <= e_rd_d;
      e_load_q <= e_load_d;
      m_vld_q  <= e_vld_q;
      m_rd_q   <= e_rd_q;
      m_load_q <= e_load_q;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: each step drives decode fields, queues the
// expected same-cycle outputs, then pops and checks them mid-cycle.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       f2d;
    logic       d2e;
    logic       bub;
    logic       fl;
    logic [1:0] f1;
    logic [1:0] f2;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
  } din_t;

  logic       clk;
  logic       rst;
  logic       dec_valid;
  logic [4:0] dec_rs1_addr, dec_rs2_addr, dec_rd_addr;
  logic       dec_rs1_used, dec_rs2_used, dec_rd_write, dec_is_load, branch_taken;
  logic       f_to_d_enable, d_to_e_enable, d_to_e_bubble, flush_fetch;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  pipeline_hazard_ctrl #(.REGISTER_SIZE(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd_addr(dec_rd_addr), .dec_rd_write(dec_rd_write),
    .dec_is_load(dec_is_load), .branch_taken(branch_taken),
    .f_to_d_enable(f_to_d_enable), .d_to_e_enable(d_to_e_enable),
    .d_to_e_bubble(d_to_e_bubble), .flush_fetch(flush_fetch),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic f2d, input logic d2e, input logic bub,
                              input logic fl, input logic [1:0] f1, input logic [1:0] f2);
    exp_t e;
    e.f2d = f2d; e.d2e = d2e; e.bub = bub; e.fl = fl; e.f1 = f1; e.f2 = f2;
    return e;
  endfunction

  function automatic din_t dec(input logic v, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic wr,
                               input logic ld, input logic br);
    din_t d;
    d.v = v; d.rs1 = rs1; d.u1 = u1; d.rs2 = rs2; d.u2 = u2;
    d.rd = rd; d.wr = wr; d.ld = ld; d.br = br;
    return d;
  endfunction

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input string tag, input din_t d, input exp_t e);
    exp_t want, got;
    dec_valid    = d.v;
    dec_rs1_addr = d.rs1;
    dec_rs2_addr = d.rs2;
    dec_rs1_used = d.u1;
    dec_rs2_used = d.u2;
    dec_rd_addr  = d.rd;
    dec_rd_write = d.wr;
    dec_is_load  = d.ld;
    branch_taken = d.br;
    exp_q.push_back(e);
    #3;
    got = mk(f_to_d_enable, d_to_e_enable, d_to_e_bubble, flush_fetch, fwd_sel_rs1, fwd_sel_rs2);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, got);
    end else begin
      want = exp_q.pop_front();
      assert (got === want) else begin
        errors++;
        $error("FAIL %s: observed f2d/d2e/bub/fl/fwd1/fwd2=%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%0d/%0d",
               tag, got.f2d, got.d2e, got.bub, got.fl, got.f1, got.f2,
               want.f2d, want.d2e, want.bub, want.fl, want.f1, want.f2);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t run0;
    run0 = mk(1, 1, 0, 0, 0, 0);
    rst = 1'b1;
    dec_valid = 0; dec_rs1_addr = 0; dec_rs2_addr = 0; dec_rs1_used = 0; dec_rs2_used = 0;
    dec_rd_addr = 0; dec_rd_write = 0; dec_is_load = 0; branch_taken = 0;
    @(posedge clk);
    #1;

    // Reset holds outputs at defaults even with a branch presented.
    step("reset_hold", dec(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 1, 1), run0);
    rst = 1'b0;

    // EX->decode forwarding, nop gating, MEM ALU forwarding, E over M priority.
    step("add_x5",      dec(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0), run0);
    step("fwd_ex_rs1",  dec(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0), mk(1, 1, 0, 0, 2, 0));
    step("nop_no_fwd",  dec(0, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 0), run0);
    step("fwd_mem_alu", dec(1, 5'd6, 1, 5'd2, 1, 5'd10, 1, 0, 0), mk(1, 1, 0, 0, 3, 0));
    step("rewrite_x10", dec(1, 5'd10, 1, 5'd3, 1, 5'd10, 1, 0, 0), mk(1, 1, 0, 0, 2, 0));
    step("e_over_m",    dec(1, 5'd10, 1, 5'd10, 1, 5'd12, 1, 0, 0), mk(1, 1, 0, 0, 2, 2));
    step("write_x0",    dec(1, 5'd12, 1, 5'd2, 1, 5'd0, 1, 0, 0), mk(1, 1, 0, 0, 2, 0));
    step("read_x0",     dec(1, 5'd0, 1, 5'd12, 0, 5'd0, 0, 0, 0), run0);

    // Load-use stall, then load data forwarded from MEM.
    step("lw_x7",       dec(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0), run0);
    step("load_stall",  dec(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0), mk(0, 0, 1, 0, 0, 0));
    step("fwd_mem_dm",  dec(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 0), mk(1, 1, 0, 0, 1, 1));

    // Load then taken branch on its result: stall first, then flush.
    step("lw_x3",       dec(1, 5'd8, 1, 5'd0, 0, 5'd3, 1, 1, 0), mk(1, 1, 0, 0, 2, 0));
    step("stall_wins",  dec(1, 5'd3, 1, 5'd8, 1, 5'd0, 0, 0, 1), mk(0, 0, 1, 0, 0, 3));
    step("branch_go",   dec(1, 5'd3, 1, 5'd8, 1, 5'd0, 0, 0, 1), mk(1, 1, 0, 1, 1, 0));
    step("flush_1",     dec(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1), mk(1, 1, 1, 1, 0, 0));
    step("flush_2",     dec(1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 0), mk(1, 1, 1, 1, 0, 0));
    step("post_flush",  dec(1, 5'd9, 1, 5'd9, 1, 5'd11, 1, 0, 0), run0);

    // Reset during flush with cnt=1 aborts the sequence and clears the scoreboard.
    step("branch_x4",   dec(1, 5'd11, 1, 5'd0, 0, 5'd4, 1, 0, 1), mk(1, 1, 0, 1, 2, 0));
    rst = 1'b1;
    step("rst_in_flush", dec(1, 5'd4, 1, 5'd4, 1, 5'd0, 0, 0, 0), run0);
    rst = 1'b0;
    step("post_rst_1",  dec(1, 5'd4, 1, 5'd4, 1, 5'd0, 0, 0, 0), run0);
    step("post_rst_2",  dec(1, 5'd11, 1, 5'd4, 1, 5'd0, 0, 0, 0), run0);

    if (exp_q.size() != 0) begin
      errors++;
      $error("FAIL leftover: %0d expected entries never compared, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
